uart_rcv: RTL and testbench

UART_RCV -- requirements
Module: uart_rcv

---
 rtl/uart_rcv.sv | 99 +++++++++
 tb/tb_uart_rcv.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rcv.sv
// rtl/uart_rcv.sv - 8N1 UART receiver with mid-bit sampling and ready/framing/overrun flags.
module uart_rcv #(
  parameter int BAUD_DIV = 2604,
  parameter int HALF_DIV = BAUD_DIV / 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy,
  output logic       frm_err,
  output logic       ovr_err
);

  localparam logic [11:0] BAUD_LAST = 12'(BAUD_DIV - 1);
  localparam logic [11:0] HALF_LAST = 12'(HALF_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state;
  logic        sync1;
  logic        sync2;
  logic        sync_prev;
  logic [11:0] baud_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      sync_prev <= 1'b1;
      state     <= IDLE;
      baud_cnt  <= 12'd0;
      bit_cnt   <= 3'd0;
      shift     <= 8'h00;
      rx_data   <= 8'h00;
      rdy       <= 1'b0;
      frm_err   <= 1'b0;
      ovr_err   <= 1'b0;
    end else begin
      sync1     <= RX;
      sync2     <= sync1;
      sync_prev <= sync2;

      // Frame-end updates below are later in the block, so they override this clear.
      if (clr_rdy) begin
        rdy     <= 1'b0;
        frm_err <= 1'b0;
        ovr_err <= 1'b0;
      end

      case (state)
        IDLE: begin
          baud_cnt <= 12'd0;
          if (!sync2 && sync_prev) state <= START;
        end
        START: begin
          if (baud_cnt == HALF_LAST) begin
            baud_cnt <= 12'd0;
            bit_cnt  <= 3'd0;
            state    <= sync2 ? IDLE : DATA;
          end else begin
            baud_cnt <= baud_cnt + 12'd1;
          end
        end
        DATA: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= 12'd0;
            shift    <= {sync2, shift[7:1]};
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= STOP;
          end else begin
            baud_cnt <= baud_cnt + 12'd1;
          end
        end
        STOP: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= 12'd0;
            state    <= IDLE;
            if (sync2) begin
              rx_data <= shift;
              rdy     <= 1'b1;
              frm_err <= 1'b0;
              if (rdy) ovr_err <= 1'b1;
            end else begin
              frm_err <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 12'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rcv.sv
// tb/tb_uart_rcv.sv - randomized frame bench for uart_rcv against a frame-level output model.
module tb_uart_rcv;
  localparam int BAUD = 32;
  localparam int HALF = 16;
  localparam int N    = HALF + 9 * BAUD;

  logic       clk = 1'b0;
  logic       rst;
  logic       RX;
  logic       clr_rdy;
  logic [7:0] rx_data;
  logic       rdy;
  logic       frm_err;
  logic       ovr_err;

  uart_rcv #(.BAUD_DIV(BAUD), .HALF_DIV(HALF)) dut (
    .clk     (clk),
    .rst     (rst),
    .RX      (RX),
    .clr_rdy (clr_rdy),
    .rx_data (rx_data),
    .rdy     (rdy),
    .frm_err (frm_err),
    .ovr_err (ovr_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected visible state, updated once per completed frame or clear pulse.
  logic [7:0] m_data = 8'h00;
  logic       m_rdy = 1'b0, m_frm = 1'b0, m_ovr = 1'b0;
  bit         busy = 1'b0;
  bit         lat_armed = 1'b0;
  int         fall_cyc = 0;
  int         passed = 0, total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(negedge clk) begin
    if (!busy)
      check("outputs{data,rdy,frm,ovr}", 32'({rx_data, rdy, frm_err, ovr_err}),
            32'({m_data, m_rdy, m_frm, m_ovr}));
  end

  always @(negedge clk) begin
    if (lat_armed && rdy === 1'b1) begin
      lat_armed = 1'b0;
      total++;
      if (cyc - fall_cyc >= N - 3 && cyc - fall_cyc <= N + 7) passed++;
      else $display("FAIL rdy_latency: got %0d clocks expected %0d..%0d", cyc - fall_cyc, N - 3, N + 7);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse_clr();
    clr_rdy = 1'b1;
    tick();
    clr_rdy = 1'b0;
    m_rdy = 1'b0;
    m_frm = 1'b0;
    m_ovr = 1'b0;
  endtask

  task automatic glitch(input int len);
    RX = 1'b0;
    idle(len);
    RX = 1'b1;
    idle(HALF + 8);
  endtask

  // abort_bit >= 0 pulses rst in the middle of that data bit and abandons the frame.
  task automatic send_frame(input logic [7:0] b, input logic stop, input bit clr_at_accept,
                            input int abort_bit);
    logic [9:0] bits;
    logic       rdy_before;
    bits = {stop, b, 1'b0};
    rdy_before = m_rdy;
    fall_cyc = cyc;
    lat_armed = stop && (!m_rdy || clr_at_accept) && abort_bit < 0;
    for (int i = 0; i < 10; i++) begin
      RX = bits[i];
      if (i == 9) busy = 1'b1;
      for (int j = 0; j < BAUD; j++) begin
        if (abort_bit >= 0 && i == abort_bit + 1 && j == HALF) begin
          rst = 1'b1;
          m_data = 8'h00; m_rdy = 1'b0; m_frm = 1'b0; m_ovr = 1'b0;
          lat_armed = 1'b0;
          #1;
          check("reset_immediate", 32'({rx_data, rdy, frm_err, ovr_err}), 32'd0);
          tick();
          rst = 1'b0;
          RX = 1'b1;
          return;
        end
        clr_rdy = clr_at_accept && (i * BAUD + j == N + 2);
        tick();
      end
    end
    clr_rdy = 1'b0;
    RX = 1'b1;
    if (stop) begin
      m_ovr = rdy_before ? 1'b1 : (clr_at_accept ? 1'b0 : m_ovr);
      m_data = b;
      m_rdy = 1'b1;
      m_frm = 1'b0;
    end else begin
      m_frm = 1'b1;
    end
    busy = 1'b0;
    if (lat_armed) begin
      lat_armed = 1'b0;
      total++;
      $display("FAIL rdy_latency: rdy never rose, expected within %0d..%0d clocks", N - 3, N + 7);
    end
  endtask

  initial begin
    rst = 1'b1;
    RX = 1'b1;
    clr_rdy = 1'b0;
    idle(3);
    check("reset_state", 32'({rx_data, rdy, frm_err, ovr_err}), 32'd0);
    rst = 1'b0;
    idle(5);

    send_frame(8'hA5, 1'b1, 1'b0, -1);
    check("a5_data", 32'(rx_data), 32'h0A5);
    check("a5_rdy", 32'(rdy), 32'd1);
    check("a5_frm", 32'(frm_err), 32'd0);
    pulse_clr();
    check("a5_clr_rdy", 32'(rdy), 32'd0);

    send_frame(8'h00, 1'b1, 1'b0, -1);
    send_frame(8'hFF, 1'b1, 1'b0, -1);
    check("b2b_data", 32'(rx_data), 32'h0FF);
    check("b2b_rdy", 32'(rdy), 32'd1);
    check("b2b_ovr", 32'(ovr_err), 32'd1);
    pulse_clr();
    check("b2b_clr_ovr", 32'(ovr_err), 32'd0);

    glitch(6);
    check("glitch_rdy_frm", 32'({rdy, frm_err}), 32'd0);
    send_frame(8'h3C, 1'b1, 1'b0, -1);
    check("3c_data", 32'(rx_data), 32'h03C);
    pulse_clr();

    send_frame(8'h81, 1'b0, 1'b0, -1);
    check("81_frm", 32'(frm_err), 32'd1);
    check("81_rdy", 32'(rdy), 32'd0);
    check("81_data_kept", 32'(rx_data), 32'h03C);
    idle(4);
    send_frame(8'h42, 1'b1, 1'b0, -1);
    check("42_flags", 32'({rdy, frm_err}), 32'b10);
    check("42_data", 32'(rx_data), 32'h042);
    pulse_clr();

    send_frame(8'h55, 1'b1, 1'b0, 4);
    idle(3 * BAUD);
    send_frame(8'h66, 1'b1, 1'b0, -1);
    check("66_data", 32'(rx_data), 32'h066);
    check("66_rdy", 32'(rdy), 32'd1);
    pulse_clr();

    send_frame(8'h17, 1'b1, 1'b1, -1);
    check("17_rdy_wins", 32'(rdy), 32'd1);
    check("17_data", 32'(rx_data), 32'h017);
    pulse_clr();

    repeat (60) begin
      logic [7:0] b;
      logic       stop;
      b = 8'($urandom);
      stop = ($urandom_range(0, 7) != 0);
      send_frame(b, stop, 1'b0, -1);
      idle(stop ? $urandom_range(0, 20) : $urandom_range(2, 10));
      if ($urandom_range(0, 2) == 0) pulse_clr();
      if ($urandom_range(0, 6) == 0) glitch($urandom_range(1, HALF - 4));
    end
    idle(10);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
